// File: rtl/display_multi_if.sv
// Value load channel for the seven-segment display driver.
// The master presents a value with a valid strobe; the slave reports busy.
interface display_multi_if #(
    parameter int IN_WIDTH = 14
);
    logic [IN_WIDTH-1:0] value_i;
    logic                value_valid_i;
    logic                busy_o;

    modport master (
        output value_i,
        output value_valid_i,
        input  busy_o
    );

    modport slave (
        input  value_i,
        input  value_valid_i,
        output busy_o
    );
endinterface

// File: rtl/display_multi.sv
// Multiplexed common-anode seven-segment driver with a sequential
// double-dabble converter, leading-zero blanking and overflow dashes.
module display_multi #(
    parameter int NUM_DIGITS       = 4,
    parameter int IN_WIDTH         = 14,
    parameter int REFRESH_OVERFLOW = 2**19-1
) (
    input  logic                  clk,
    input  logic                  reset,
    display_multi_if.slave        bus,
    input  logic                  blank_lz_i,
    output logic                  overflow_o,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic [6:0]            led_select
);

    // Decimal digits needed for 2**IN_WIDTH-1 (log10(2) ~= 0.30103).
    localparam int NEED = (IN_WIDTH * 30103) / 100000 + 1;
    localparam int TOT  = (NEED > NUM_DIGITS) ? NEED : NUM_DIGITS;
    localparam int SW   = TOT * 4;
    localparam int DW   = NUM_DIGITS * 4;
    localparam int CW   = $clog2(IN_WIDTH) + 1;
    localparam int RW   = (REFRESH_OVERFLOW > 0) ?
                          $clog2(REFRESH_OVERFLOW + 1) : 1;
    localparam int XW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] LAST_STEP = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_OVERFLOW);
    localparam logic [XW-1:0] LAST_IDX  = XW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IN_WIDTH-1:0] sh_q, sh_d;
    logic [SW-1:0]   scr_q, scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic            ovf_q, ovf_d;
    logic [RW-1:0]   ref_q, ref_d;
    logic [XW-1:0]   idx_q, idx_d;
    logic            blank_q, blank_d;

    logic [SW-1:0]   adj;
    logic            hi_nz;
    logic [3:0]      nib;
    logic            allz;
    logic            blanked;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load on request, IN_WIDTH shift steps, then commit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.value_valid_i) state_d = S_CONV;
            S_CONV:  if (cnt_q == LAST_STEP) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Add-3 correction of every nibble >= 5 ahead of the shift.
    always_comb begin
        adj   = scr_q;
        hi_nz = 1'b0;
        for (int i = 0; i < TOT; i++) begin
            if (scr_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
            end
            if (i >= NUM_DIGITS) begin
                hi_nz = hi_nz | (|scr_q[i*4 +: 4]);
            end
        end
    end

    // Datapath next values: converter, display latch, refresh scan.
    always_comb begin
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        blank_d = blank_lz_i;
        ref_d   = ref_q + RW'(1);
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.value_valid_i) begin
                    sh_d  = bus.value_i;
                    scr_d = '0;
                    cnt_d = '0;
                end
            end
            S_CONV: begin
                sh_d  = sh_q << 1;
                scr_d = (adj << 1) | SW'(sh_q[IN_WIDTH-1]);
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE: begin
                disp_d = scr_q[DW-1:0];
                ovf_d  = hi_nz;
            end
            default: ;
        endcase

        if (ref_q == REF_MAX) begin
            ref_d = '0;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + XW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
        end
    end

    // Pick the active nibble and decide whether it is a leading zero.
    always_comb begin
        nib          = 4'd0;
        allz         = 1'b1;
        blanked      = 1'b0;
        digit_select = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allz = allz & (disp_q[i*4 +: 4] == 4'd0);
            if (idx_q == XW'(i)) begin
                nib             = disp_q[i*4 +: 4];
                blanked         = allz && (i != 0);
                digit_select[i] = 1'b0;
            end
        end
    end

    // Segment pattern {g,f,e,d,c,b,a}, active low.
    always_comb begin
        led_select = 7'b1111111;
        if (ovf_q) begin
            led_select = 7'b0111111;
        end else if (blank_q && blanked) begin
            led_select = 7'b1111111;
        end else begin
            unique case (nib)
                4'd0:    led_select = 7'b1000000;
                4'd1:    led_select = 7'b1111001;
                4'd2:    led_select = 7'b0100100;
                4'd3:    led_select = 7'b0110000;
                4'd4:    led_select = 7'b0011001;
                4'd5:    led_select = 7'b0010010;
                4'd6:    led_select = 7'b0000010;
                4'd7:    led_select = 7'b1111000;
                4'd8:    led_select = 7'b0000000;
                4'd9:    led_select = 7'b0010000;
                default: led_select = 7'b1111111;
            endcase
        end
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_display_multi.sv
// Directed bench for display_multi: refresh scan, conversion timing,
// overflow, blanking, ignored requests and reset abort.
module tb_display_multi;

    localparam int ND = 4;
    localparam int IW = 14;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG2 = 7'b0100100;
    localparam logic [6:0] SEG3 = 7'b0110000;
    localparam logic [6:0] SEG4 = 7'b0011001;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG7 = 7'b1111000;
    localparam logic [6:0] SEG8 = 7'b0000000;
    localparam logic [6:0] SEG9 = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLNK = 7'b1111111;

    logic          clk;
    logic          reset;
    logic          blank_lz_i;
    logic          overflow_o;
    logic [ND-1:0] digit_select;
    logic [6:0]    led_select;

    int total = 0;
    int bad   = 0;

    display_multi_if #(.IN_WIDTH(IW)) bus ();

    display_multi #(
        .NUM_DIGITS       (ND),
        .IN_WIDTH         (IW),
        .REFRESH_OVERFLOW (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .blank_lz_i   (blank_lz_i),
        .overflow_o   (overflow_o),
        .digit_select (digit_select),
        .led_select   (led_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for digit d to be scanned, then check its segments.
    task automatic show(input int d, input logic [6:0] exp,
                        input string tag);
        logic [ND-1:0] want;
        int n;
        want = ~(ND'(1) << d);
        n = 0;
        while (digit_select !== want && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_sel"}, 32'(digit_select), 32'(want));
        chk(tag, 32'(led_select), 32'(exp));
    endtask

    // Issue a one-cycle request and wait (bounded) for completion.
    task automatic send(input logic [IW-1:0] v);
        int n;
        bus.value_i       = v;
        bus.value_valid_i = 1'b1;
        step();
        bus.value_valid_i = 1'b0;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("conv_done", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] w;
        reset             = 1'b1;
        blank_lz_i        = 1'b0;
        bus.value_i       = '0;
        bus.value_valid_i = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // 1: reset state and refresh scan order
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_sel", 32'(digit_select), 32'b1110);
        chk("rst_led", 32'(led_select), 32'(SEG0));
        for (int j = 0; j < 16; j++) begin
            w = ~(ND'(1) << (j / 4));
            chk($sformatf("scan%0d", j), 32'(digit_select), 32'(w));
            chk($sformatf("scan_led%0d", j), 32'(led_select), 32'(SEG0));
            step();
        end
        blank_lz_i = 1'b1;
        step();
        show(2, BLNK, "lz_d2");
        show(0, SEG0, "lz_d0");
        blank_lz_i = 1'b0;
        step();

        // 2: 1234 with exact busy timing and no partial update
        bus.value_i       = 14'd1234;
        bus.value_valid_i = 1'b1;
        step();
        bus.value_valid_i = 1'b0;
        chk("busy_k", 32'(bus.busy_o), 32'd1);
        repeat (14) step();
        chk("busy_k14", 32'(bus.busy_o), 32'd1);
        chk("no_partial", 32'(led_select), 32'(SEG0));
        step();
        chk("busy_k15", 32'(bus.busy_o), 32'd0);
        chk("ovf_1234", 32'(overflow_o), 32'd0);
        show(3, SEG1, "v1234_d3");
        show(2, SEG2, "v1234_d2");
        show(1, SEG3, "v1234_d1");
        show(0, SEG4, "v1234_d0");

        // 3: largest displayable value, then first overflowing value
        send(14'd9999);
        chk("ovf_9999", 32'(overflow_o), 32'd0);
        show(3, SEG9, "v9999_d3");
        show(0, SEG9, "v9999_d0");
        send(14'd10000);
        chk("ovf_10000", 32'(overflow_o), 32'd1);
        show(0, DASH, "ovf_d0");
        show(3, DASH, "ovf_d3");

        // 4: leading-zero blanking and its one-cycle lag
        blank_lz_i = 1'b1;
        send(14'd7);
        chk("ovf_7", 32'(overflow_o), 32'd0);
        show(0, SEG7, "v7_d0");
        show(3, BLNK, "v7_d3");
        show(0, SEG7, "v7_d0b");
        show(1, BLNK, "v7_d1");
        blank_lz_i = 1'b0;
        chk("lz_lag", 32'(led_select), 32'(BLNK));
        step();
        chk("lz_off", 32'(led_select), 32'(SEG0));
        show(2, SEG0, "v7_d2");

        // 5: request during busy is dropped, not queued
        bus.value_i       = 14'd8;
        bus.value_valid_i = 1'b1;
        step();
        bus.value_valid_i = 1'b0;
        repeat (3) step();
        bus.value_i       = 14'd55;
        bus.value_valid_i = 1'b1;
        step();
        bus.value_valid_i = 1'b0;
        repeat (16) step();
        chk("no_queue", 32'(bus.busy_o), 32'd0);
        show(0, SEG8, "v8_d0");
        show(1, SEG0, "v8_d1");
        send(14'd55);
        show(0, SEG5, "v55_d0");
        show(1, SEG5, "v55_d1");

        // 6: reset mid-conversion discards the pending value
        send(14'd12345);
        chk("ovf_12345", 32'(overflow_o), 32'd1);
        bus.value_i       = 14'd4321;
        bus.value_valid_i = 1'b1;
        step();
        bus.value_valid_i = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_ovf", 32'(overflow_o), 32'd0);
        chk("abort_sel", 32'(digit_select), 32'b1110);
        chk("abort_led", 32'(led_select), 32'(SEG0));
        repeat (20) step();
        chk("abort_idle", 32'(bus.busy_o), 32'd0);
        show(3, SEG0, "abort_d3");
        show(0, SEG0, "abort_d0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
